// File: rtl/sseg_scan_mux_if.sv
// Bus between the display scanner and whatever feeds it digits / consumes its slots.
// The master drives the digit data and enable; the scanner (slave) returns the current slot.
interface sseg_scan_mux_if #(
    parameter int DIGIT_COUNT = 8
);
    localparam int SEL_W = $clog2(DIGIT_COUNT);

    logic                     enIn;
    logic [4*DIGIT_COUNT-1:0] bcdVecIn;
    logic [DIGIT_COUNT-1:0]   digitEnIn;
    logic [SEL_W-1:0]         selOut;
    logic [3:0]               bcdOut;
    logic                     frameOut;

    modport master (
        output enIn, bcdVecIn, digitEnIn,
        input  selOut, bcdOut, frameOut
    );

    modport slave (
        input  enIn, bcdVecIn, digitEnIn,
        output selOut, bcdOut, frameOut
    );
endinterface

// File: rtl/sseg_scan_mux.sv
// Seven-segment time-multiplexing scanner: steps one digit per refresh slot, snapshots
// the input once per frame and emits the blank code 4'hF for masked or leading-zero digits.
module sseg_scan_mux #(
    parameter int DIGIT_COUNT   = 8,
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input logic            clkIn,
    input logic            rstIn,
    sseg_scan_mux_if.slave bus
);
    localparam int SEL_W = $clog2(DIGIT_COUNT);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(DIGIT_COUNT - 1);
    localparam logic [PRE_W-1:0] LAST_PRE   = PRE_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       BLANK_CODE = 4'hF;

    logic [PRE_W-1:0]         prescaler;
    logic [SEL_W-1:0]         selReg;
    logic [3:0]               bcdReg;
    logic                     frameReg;
    logic [4*DIGIT_COUNT-1:0] snapBcd;
    logic [DIGIT_COUNT-1:0]   snapEn;

    logic                     tick;
    logic                     wrap;
    logic [SEL_W-1:0]         nextSel;
    logic [4*DIGIT_COUNT-1:0] srcBcd;
    logic [DIGIT_COUNT-1:0]   srcEn;
    logic [DIGIT_COUNT-1:0]   blankVec;
    logic                     allZero;
    logic [3:0]               nextBcd;

    // On the wrap tick the new digit 0 must come from the values being captured, not the old frame.
    always_comb begin
        tick    = bus.enIn && (prescaler == LAST_PRE);
        wrap    = tick && (selReg == LAST_SEL);
        nextSel = (selReg == LAST_SEL) ? '0 : selReg + SEL_W'(1);
        srcBcd  = wrap ? bus.bcdVecIn  : snapBcd;
        srcEn   = wrap ? bus.digitEnIn : snapEn;
    end

    // Walk from the top digit down so allZero means "this digit and everything above it is 0".
    always_comb begin
        allZero  = 1'b1;
        blankVec = '0;
        for (int i = DIGIT_COUNT - 1; i >= 0; i--) begin
            allZero     = allZero && (srcBcd[4*i +: 4] == 4'h0);
            blankVec[i] = !srcEn[i] || (BLANK_LEADING && (i > 0) && allZero);
        end
        nextBcd = BLANK_CODE;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            if (nextSel == SEL_W'(i)) begin
                nextBcd = blankVec[i] ? BLANK_CODE : srcBcd[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            prescaler <= '0;
            selReg    <= LAST_SEL;
            bcdReg    <= BLANK_CODE;
            frameReg  <= 1'b0;
            snapBcd   <= '0;
            snapEn    <= '1;
        end else begin
            frameReg <= 1'b0;
            if (bus.enIn) begin
                prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                if (tick) begin
                    selReg <= nextSel;
                    bcdReg <= nextBcd;
                end
                if (wrap) begin
                    snapBcd  <= bus.bcdVecIn;
                    snapEn   <= bus.digitEnIn;
                    frameReg <= 1'b1;
                end
            end
        end
    end

    assign bus.selOut   = selReg;
    assign bus.bcdOut   = bcdReg;
    assign bus.frameOut = frameReg;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux: two instances (leading-zero blanking off / on) driven
// with identical stimulus; per-digit expectations are hand-computed in the vector table.
module tb_sseg_scan_mux;
    localparam int DC = 4;
    localparam int RD = 4;

    typedef struct {
        string            name;
        logic [15:0]      bcd;
        logic [3:0]       digEn;
        logic [3:0][3:0]  expPlain;
        logic [3:0][3:0]  expBlank;
    } vector_t;

    logic clkIn = 1'b0;
    logic rstIn = 1'b1;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clkIn = ~clkIn;

    sseg_scan_mux_if #(.DIGIT_COUNT(DC)) busPlain ();
    sseg_scan_mux_if #(.DIGIT_COUNT(DC)) busBlank ();

    sseg_scan_mux #(.DIGIT_COUNT(DC), .REFRESH_DIV(RD), .BLANK_LEADING(1'b0)) dutPlain (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (busPlain)
    );

    sseg_scan_mux #(.DIGIT_COUNT(DC), .REFRESH_DIV(RD), .BLANK_LEADING(1'b1)) dutBlank (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (busBlank)
    );

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] bcd, input logic [3:0] digEn);
        busPlain.enIn      = en;
        busPlain.bcdVecIn  = bcd;
        busPlain.digitEnIn = digEn;
        busBlank.enIn      = en;
        busBlank.bcdVecIn  = bcd;
        busBlank.digitEnIn = digEn;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkSlot(input string name, input logic [1:0] sel, input logic [3:0] bcdPlain,
                             input logic [3:0] bcdBlank, input logic frame);
        checkOutput({name, " selPlain"},   8'(busPlain.selOut),   8'(sel));
        checkOutput({name, " selBlank"},   8'(busBlank.selOut),   8'(sel));
        checkOutput({name, " bcdPlain"},   8'(busPlain.bcdOut),   8'(bcdPlain));
        checkOutput({name, " bcdBlank"},   8'(busBlank.bcdOut),   8'(bcdBlank));
        checkOutput({name, " framePlain"}, 8'(busPlain.frameOut), 8'(frame));
        checkOutput({name, " frameBlank"}, 8'(busBlank.frameOut), 8'(frame));
    endtask

    // Steps at least once so a stale pulse is never mistaken for the next frame.
    task automatic waitFrame(input string name);
        int n = 0;
        stepCycles(1);
        while (busPlain.frameOut !== 1'b1 && n < 64) begin
            stepCycles(1);
            n++;
        end
        checkOutput({name, " frame seen"}, 8'(busPlain.frameOut), 8'h01);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_t vecs[7];
        vecs[0] = '{"scan1234",   16'h1234, 4'hF, 16'h1234, 16'h1234};
        vecs[1] = '{"lead0050",   16'h0050, 4'hF, 16'h0050, 16'hFF50};
        vecs[2] = '{"lead0000",   16'h0000, 4'hF, 16'h0000, 16'hFFF0};
        vecs[3] = '{"lead0102",   16'h0102, 4'hF, 16'h0102, 16'hF102};
        vecs[4] = '{"mask1010",   16'h1234, 4'hA, 16'h1F3F, 16'h1F3F};
        vecs[5] = '{"nonBcd00A0", 16'h00A0, 4'hF, 16'h00A0, 16'hFFA0};
        vecs[6] = '{"maskDigit0", 16'h0000, 4'hE, 16'h000F, 16'hFFFF};

        // Reset held two cycles, then the first frame arrives after RD enabled cycles.
        rstIn = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'hF);
        stepCycles(2);
        checkSlot("reset", 2'd3, 4'hF, 4'hF, 1'b0);
        rstIn = 1'b0;
        stepCycles(3);
        checkSlot("preFirstTick", 2'd3, 4'hF, 4'hF, 1'b0);
        stepCycles(1);
        checkSlot("firstTick", 2'd0, 4'h4, 4'h4, 1'b1);
        stepCycles(1);
        checkSlot("framePulseEnds", 2'd0, 4'h4, 4'h4, 1'b0);
        stepCycles(2);
        checkSlot("slotHold", 2'd0, 4'h4, 4'h4, 1'b0);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(1'b1, vecs[v].bcd, vecs[v].digEn);
            waitFrame(vecs[v].name);
            for (int d = 0; d < DC; d++) begin
                if (d > 0) stepCycles(RD);
                checkSlot($sformatf("%s d%0d", vecs[v].name, d), 2'(d),
                          vecs[v].expPlain[d], vecs[v].expBlank[d], (d == 0) ? 1'b1 : 1'b0);
            end
        end

        // Input changes mid-frame must not tear the current frame.
        applyStimulus(1'b1, 16'h1234, 4'hF);
        waitFrame("snap");
        checkSlot("snap d0", 2'd0, 4'h4, 4'h4, 1'b1);
        stepCycles(RD);
        checkSlot("snap d1", 2'd1, 4'h3, 4'h3, 1'b0);
        applyStimulus(1'b1, 16'h9876, 4'hF);
        stepCycles(RD);
        checkSlot("snap d2 old", 2'd2, 4'h2, 4'h2, 1'b0);
        stepCycles(RD);
        checkSlot("snap d3 old", 2'd3, 4'h1, 4'h1, 1'b0);
        stepCycles(RD);
        checkSlot("snap d0 new", 2'd0, 4'h6, 4'h6, 1'b1);
        stepCycles(RD);
        checkSlot("snap d1 new", 2'd1, 4'h7, 4'h7, 1'b0);
        stepCycles(RD);
        checkSlot("snap d2 new", 2'd2, 4'h8, 4'h8, 1'b0);
        stepCycles(RD);
        checkSlot("snap d3 new", 2'd3, 4'h9, 4'h9, 1'b0);

        // Freeze mid-slot: two enabled cycles used, two remain after resuming.
        waitFrame("freeze");
        stepCycles(2);
        applyStimulus(1'b0, 16'h9876, 4'hF);
        stepCycles(10);
        checkSlot("frozen", 2'd0, 4'h6, 4'h6, 1'b0);
        applyStimulus(1'b1, 16'h9876, 4'hF);
        stepCycles(1);
        checkSlot("resume1", 2'd0, 4'h6, 4'h6, 1'b0);
        stepCycles(1);
        checkSlot("resume2", 2'd1, 4'h7, 4'h7, 1'b0);

        // Enable dropped exactly on the tick cycle: tick deferred to the next enabled cycle.
        stepCycles(3);
        applyStimulus(1'b0, 16'h9876, 4'hF);
        stepCycles(3);
        checkSlot("tickStalled", 2'd1, 4'h7, 4'h7, 1'b0);
        applyStimulus(1'b1, 16'h9876, 4'hF);
        stepCycles(1);
        checkSlot("tickResumed", 2'd2, 4'h8, 4'h8, 1'b0);

        // Reset pulse while digit 2 is shown restarts the frame like power-on.
        rstIn = 1'b1;
        stepCycles(1);
        checkSlot("midReset", 2'd3, 4'hF, 4'hF, 1'b0);
        rstIn = 1'b0;
        stepCycles(3);
        checkSlot("midResetWait", 2'd3, 4'hF, 4'hF, 1'b0);
        stepCycles(1);
        checkSlot("midResetFrame", 2'd0, 4'h6, 4'h6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
